ram_responder: RTL and testbench

//  RAM-side responder for the memory controller's 16-bit halfword RAM interface.

---
 rtl/ram_responder.sv | 132 +++++++++++++
 tb/tb_ram_responder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// RAM-side responder for the memory controller's 16-bit halfword bus.
// Asynchronous-read / clocked-write SRAM plus a byte-stream boot loader that
// owns the array (and holds off the controller via ram_busy) while it runs.
module ram_responder #(
    parameter int unsigned ADDR_W   = 18,
    parameter string       INIT_HEX = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [17:0] mc_ram_addr,
    input  logic        mc_ram_wre,
    inout  wire  [15:0] mc_ram_data,
    output logic        ram_busy,
    input  logic        ld_start,
    input  logic [17:0] ld_base,
    input  logic        ld_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done,
    output logic [17:0] ld_ptr
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned PORT_W = 18;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WR,
        S_WR_LAST,
        S_DONE
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state_q, state_n;
    logic [DATA_W-1:0]   hold_q, hold_n;
    logic [ADDR_W-1:0]   ptr_q, ptr_n;
    logic                busy_q, ready_q, done_q;
    logic                commit_c;
    logic [ADDR_W-1:0]   mc_addr_c;

    assign mc_addr_c = mc_ram_addr[ADDR_W-1:0];
    assign commit_c  = (state_q == S_WR) || (state_q == S_WR_LAST);

    // Loader next-state, byte assembly and pointer update
    always_comb begin
        state_n = state_q;
        hold_n  = hold_q;
        ptr_n   = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (ld_start) begin
                    ptr_n   = ld_base[ADDR_W-1:0];
                    state_n = S_HI;
                end
            end
            S_HI: begin
                if (ld_valid) begin
                    hold_n[DATA_W-1:BYTE_W] = ld_byte;
                    if (ld_last) begin
                        hold_n[BYTE_W-1:0] = BYTE_W'(0);
                        state_n            = S_WR_LAST;
                    end else begin
                        state_n = S_LO;
                    end
                end
            end
            S_LO: begin
                if (ld_valid) begin
                    hold_n[BYTE_W-1:0] = ld_byte;
                    state_n            = ld_last ? S_WR_LAST : S_WR;
                end
            end
            S_WR: begin
                ptr_n   = ptr_q + ADDR_W'(1);
                state_n = S_HI;
            end
            S_WR_LAST: begin
                ptr_n   = ptr_q + ADDR_W'(1);
                state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Loader state and registered status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            hold_q  <= hold_n;
            ptr_q   <= ptr_n;
            busy_q  <= (state_n != S_IDLE);
            ready_q <= (state_n == S_HI) || (state_n == S_LO);
            done_q  <= (state_n == S_DONE);
        end
    end

    // Array write port: loader commit has priority, controller only when idle
    always_ff @(posedge clock) begin
        if (commit_c) begin
            mem[ptr_q] <= hold_q;
        end else if (!busy_q && !mc_ram_wre) begin
            mem[mc_addr_c] <= mc_ram_data;
        end
    end

    // Combinational read; bus released during writes and while loading
    assign mc_ram_data = (mc_ram_wre && !busy_q) ? mem[mc_addr_c] : {DATA_W{1'bz}};

    assign ram_busy = busy_q;
    assign ld_ready = ready_q;
    assign ld_done  = done_q;
    assign ld_ptr   = PORT_W'(ptr_q);

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: stimulus pushes expected read data and
// expected end-of-load pointers; a negedge monitor pops and compares.
module tb_ram_responder;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [17:0] mc_ram_addr = '0;
    logic        mc_ram_wre = 1'b1;
    wire  [15:0] mc_ram_data;
    logic        ram_busy;
    logic        ld_start = 1'b0;
    logic [17:0] ld_base = '0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        ld_done;
    logic [17:0] ld_ptr;

    logic        drv_en = 1'b0;
    logic [15:0] drv_data = '0;
    logic        rd_chk = 1'b0;

    assign mc_ram_data = drv_en ? drv_data : 16'bz;

    always #5 clock = ~clock;

    ram_responder #(.ADDR_W(ADDR_W), .INIT_HEX("")) dut (
        .clock       (clock),
        .reset       (reset),
        .mc_ram_addr (mc_ram_addr),
        .mc_ram_wre  (mc_ram_wre),
        .mc_ram_data (mc_ram_data),
        .ram_busy    (ram_busy),
        .ld_start    (ld_start),
        .ld_base     (ld_base),
        .ld_valid    (ld_valid),
        .ld_byte     (ld_byte),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .ld_done     (ld_done),
        .ld_ptr      (ld_ptr)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t done_q[$];

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned done_count = 0;
    bit          prev_done = 1'b0;

    // Reference memory contents, indexed by halfword address
    logic [15:0] model [int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (prev_done) check("busy_fall_after_done", 32'(ram_busy), 32'd0);
        prev_done = ld_done;
        if (ld_done) begin
            done_count++;
            check("busy_during_done", 32'(ram_busy), 32'd1);
            if (done_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ld_done: got pulse, expected none (t=%0t)", $time);
            end else begin
                e = done_q.pop_front();
                check(e.name, 32'(ld_ptr), e.val);
            end
        end
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                total++;
                $display("FAIL rd_scoreboard_empty: got read, expected none (t=%0t)", $time);
            end else begin
                e = rd_q.pop_front();
                check(e.name, 32'(mc_ram_data), e.val);
            end
        end
    end

    task automatic wr(input logic [17:0] addr, input logic [15:0] data);
        @(posedge clock); #1;
        mc_ram_addr = addr;
        mc_ram_wre  = 1'b0;
        drv_en      = 1'b1;
        drv_data    = data;
        model[int'(addr)] = data;
        @(posedge clock); #1;
        mc_ram_wre = 1'b1;
        drv_en     = 1'b0;
    endtask

    task automatic rd(input string name, input logic [17:0] addr);
        exp_t e;
        e.name = name;
        e.val  = 32'(model[int'(addr)]);
        rd_q.push_back(e);
        @(posedge clock); #1;
        mc_ram_addr = addr;
        mc_ram_wre  = 1'b1;
        drv_en      = 1'b0;
        rd_chk      = 1'b1;
        @(posedge clock); #1;
        rd_chk = 1'b0;
    endtask

    // Runs a whole load; full=1 keeps ld_valid high, interfere=1 hammers addr 0x10
    task automatic load(input string name, input logic [17:0] base, input byte unsigned bytes[$],
                        input bit full, input bit interfere);
        int          n = bytes.size();
        int          nhw = (n + 1) / 2;
        int          idx = 0;
        int          cycles = 0;
        int unsigned d0 = done_count;
        bit          seen = 1'b0;
        bit          xfer;
        exp_t        e;
        for (int i = 0; i < nhw; i++) begin
            logic [15:0] hw;
            hw[15:8] = bytes[2*i];
            hw[7:0]  = (2*i + 1 < n) ? bytes[2*i+1] : 8'h00;
            model[(int'(base) + i) % DEPTH] = hw;
        end
        e.name = {name, "_final_ptr"};
        e.val  = 32'((int'(base) + nhw) % DEPTH);
        done_q.push_back(e);

        @(posedge clock); #1;
        ld_start = 1'b1;
        ld_base  = base;
        @(negedge clock);
        check({name, "_busy_before"}, 32'(ram_busy), 32'd0);
        @(posedge clock); #1;
        ld_start = 1'b0;
        check({name, "_busy_rise"}, 32'(ram_busy), 32'd1);

        while (!seen && cycles < 2000) begin
            if (idx < n) begin
                ld_valid = full || ($urandom_range(0, 2) != 0);
                ld_byte  = bytes[idx];
                ld_last  = (idx == n - 1);
            end else begin
                ld_valid = 1'b0;
                ld_last  = 1'b0;
            end
            if (interfere) begin
                mc_ram_addr = 18'h00010;
                if (cycles % 2 == 0) begin
                    mc_ram_wre = 1'b0;
                    drv_en     = 1'b1;
                    drv_data   = 16'h0000;
                end else begin
                    mc_ram_wre = 1'b1;
                    drv_en     = 1'b0;
                end
            end
            @(negedge clock);
            cycles++;
            if (interfere && mc_ram_wre)
                check({name, "_no_drive_while_busy"}, 32'(mc_ram_data !== model[32'h10]), 32'd1);
            if (ld_done) seen = 1'b1;
            xfer = ld_valid && ld_ready;
            @(posedge clock); #1;
            if (xfer) idx++;
        end
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        mc_ram_wre = 1'b1;
        drv_en     = 1'b0;
        if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
        if (full) check({name, "_cycles"}, 32'(cycles), 32'(3 * (n / 2) + 2 * (n % 2) + 1));
        @(negedge clock);
        @(negedge clock);
        check({name, "_done_pulses"}, 32'(done_count - d0), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        byte unsigned bq[$];
        int unsigned  d0;
        int           k;
        bit           xfer;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ram_busy", 32'(ram_busy), 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd0);
        check("rst_ld_done",  32'(ld_done),  32'd0);
        check("rst_ld_ptr",   32'(ld_ptr),   32'd0);
        reset = 1'b1;

        // Controller write then read
        wr(18'h00010, 16'hBEEF);
        rd("rd_beef", 18'h00010);

        // Even-length load at full rate
        bq = '{8'h12, 8'h34, 8'h56, 8'h78};
        load("ld_even", 18'h00100, bq, 1'b1, 1'b0);
        rd("rd_100", 18'h00100);
        rd("rd_101", 18'h00101);

        // Odd-length load: final low byte padded with zero
        bq = '{8'hAA, 8'hBB, 8'hCC};
        load("ld_odd", 18'h00200, bq, 1'b1, 1'b0);
        rd("rd_200", 18'h00200);
        rd("rd_201", 18'h00201);

        // Load across the top of the address space
        bq = '{8'hDE, 8'hAD, 8'hC0, 8'hDE};
        load("ld_wrap", 18'(DEPTH - 1), bq, 1'b1, 1'b0);
        rd("rd_top", 18'(DEPTH - 1));
        rd("rd_zero", 18'h00000);

        // Controller writes during a load are dropped and the bus is not driven
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load("ld_interf", 18'h00400, bq, 1'b0, 1'b1);
        rd("rd_10_kept", 18'h00010);
        rd("rd_400", 18'h00400);
        rd("rd_402", 18'h00402);

        // Reset after the high byte of the second halfword is accepted
        model[32'h300] = 16'h1122;
        d0 = done_count;
        @(posedge clock); #1;
        ld_start = 1'b1;
        ld_base  = 18'h00300;
        @(posedge clock); #1;
        ld_start = 1'b0;
        bq = '{8'h11, 8'h22, 8'h33};
        k  = 0;
        for (int c = 0; c < 50 && k < 3; c++) begin
            ld_valid = 1'b1;
            ld_byte  = bq[k];
            ld_last  = 1'b0;
            @(negedge clock);
            xfer = ld_ready;
            @(posedge clock); #1;
            if (xfer) k++;
        end
        ld_valid = 1'b0;
        check("midrst_bytes_taken", 32'(k), 32'd3);
        reset = 1'b0;
        #1;
        check("midrst_ram_busy", 32'(ram_busy), 32'd0);
        check("midrst_ld_ready", 32'(ld_ready), 32'd0);
        check("midrst_ld_ptr",   32'(ld_ptr),   32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("midrst_no_done", 32'(done_count - d0), 32'd0);
        rd("rd_300_kept", 18'h00300);

        // Randomized loads with stalls, each read back
        for (int t = 0; t < 4; t++) begin
            logic [17:0] base;
            int          n;
            base = 18'($urandom_range(0, DEPTH - 1));
            n    = $urandom_range(1, 8);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            load("ld_rand", base, bq, 1'b0, 1'b0);
            for (int i = 0; i < (n + 1) / 2; i++)
                rd("rd_rand_ld", 18'((int'(base) + i) % DEPTH));
        end

        // Randomized controller write/read pairs
        for (int t = 0; t < 6; t++) begin
            logic [17:0] a;
            a = 18'($urandom_range(0, DEPTH - 1));
            wr(a, 16'($urandom));
            rd("rd_rand_wr", a);
        end

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 32'(rd_q.size() + done_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
